seg7_scan_driver: RTL and testbench

//  Parametrised N-digit multiplexed hex display driver, successor to the single-digit

---
 rtl/seg7_pkg.sv | 24 ++
 rtl/seg7_hex_lut.sv | 35 +++
 rtl/seg7_scan_driver.sv | 186 ++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the multiplexed 7-segment driver.
//   SEG_OFF     - all segments dark (active-low)
//   SEG_A..G    - bit positions of each segment inside the 7-bit seg bus
//   HEX_SEG     - active-low {a,b,c,d,e,f,g} pattern for hex digits 0..F
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

endpackage

// File: rtl/seg7_hex_lut.sv
// seg7_hex_lut: combinational hex nibble to active-low segment decoder.
//   nibble - 4-bit hex value
//   seg    - active-low {a,b,c,d,e,f,g}; an unknown nibble yields all segments off
module seg7_hex_lut
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Nibble to segment pattern lookup.
    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0:    seg = HEX_SEG[0];
            4'h1:    seg = HEX_SEG[1];
            4'h2:    seg = HEX_SEG[2];
            4'h3:    seg = HEX_SEG[3];
            4'h4:    seg = HEX_SEG[4];
            4'h5:    seg = HEX_SEG[5];
            4'h6:    seg = HEX_SEG[6];
            4'h7:    seg = HEX_SEG[7];
            4'h8:    seg = HEX_SEG[8];
            4'h9:    seg = HEX_SEG[9];
            4'hA:    seg = HEX_SEG[10];
            4'hB:    seg = HEX_SEG[11];
            4'hC:    seg = HEX_SEG[12];
            4'hD:    seg = HEX_SEG[13];
            4'hE:    seg = HEX_SEG[14];
            4'hF:    seg = HEX_SEG[15];
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: N-digit time-multiplexed hex display driver for common-anode pins.
//   clk, reset        - rising-edge clock, asynchronous active-high reset
//   load              - 1-cycle strobe capturing data/blank/dp/lz_en into the shadow buffer
//   data              - hex nibbles, digit i = data[4i+3:4i], digit 0 rightmost
//   blank, dp         - per-digit dark / decimal-point-lit controls
//   lz_en             - suppress leading zeros (evaluated when the shadow is committed)
//   an, seg, dp_n     - registered active-low anode, segment and decimal-point drives
//   pending           - shadow holds content not yet committed to the display
//   frame_tick        - 1-cycle pulse following the last cycle of each scan frame
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int DEAD_CYCLES  = 500
)
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   data,
    input  logic [NUM_DIGITS-1:0]     blank,
    input  logic [NUM_DIGITS-1:0]     dp,
    input  logic                      lz_en,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [6:0]                seg,
    output logic                      dp_n,
    output logic                      pending,
    output logic                      frame_tick
);

    localparam int CNT_W = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DAT_W = 4 * NUM_DIGITS;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  pending_q, pending_d;
    logic                  frame_tick_q, frame_tick_d;
    logic [DAT_W-1:0]      sh_data_q, sh_data_d;
    logic [NUM_DIGITS-1:0] sh_blank_q, sh_blank_d;
    logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d;
    logic                  sh_lz_q, sh_lz_d;
    logic [DAT_W-1:0]      act_data_q, act_data_d;
    logic [NUM_DIGITS-1:0] act_blank_q, act_blank_d;
    logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_n_q, dp_n_d;

    logic                  slot_end;
    logic                  frame_wrap;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_run;
    logic [3:0]            cur_nibble;
    logic [6:0]            lut_seg;
    logic                  slot_lit;

    // Slot timing: cnt walks the dwell, idx walks the digits, wrap marks frame end.
    always_comb begin
        slot_end   = (cnt_q == CNT_W'(DWELL_CYCLES - 1));
        frame_wrap = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        if (slot_end) begin
            cnt_d = {CNT_W{1'b0}};
            if (frame_wrap) begin
                idx_d = {IDX_W{1'b0}};
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Leading-zero mask of the shadow: blank zeros from the top digit down to the
    // first non-zero nibble; digit 0 always stays visible.
    always_comb begin
        lz_mask  = {NUM_DIGITS{1'b0}};
        zero_run = sh_lz_q;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (zero_run && (sh_data_q[4*i +: 4] == 4'h0)) begin
                lz_mask[i] = 1'b1;
            end else begin
                zero_run = 1'b0;
            end
        end
    end

    // Double buffer: load fills the shadow, frame wrap commits it. A load coinciding
    // with the wrap commits the old shadow and keeps the new one pending.
    always_comb begin
        sh_data_d    = sh_data_q;
        sh_blank_d   = sh_blank_q;
        sh_dp_d      = sh_dp_q;
        sh_lz_d      = sh_lz_q;
        act_data_d   = act_data_q;
        act_blank_d  = act_blank_q;
        act_dp_d     = act_dp_q;
        pending_d    = pending_q;
        frame_tick_d = frame_wrap;
        if (frame_wrap && pending_q) begin
            act_data_d  = sh_data_q;
            act_blank_d = sh_blank_q | lz_mask;
            act_dp_d    = sh_dp_q;
        end else begin
            act_data_d  = act_data_q;
        end
        if (load) begin
            sh_data_d  = data;
            sh_blank_d = blank;
            sh_dp_d    = dp;
            sh_lz_d    = lz_en;
            pending_d  = 1'b1;
        end else if (frame_wrap) begin
            pending_d  = 1'b0;
        end else begin
            pending_d  = pending_q;
        end
    end

    assign cur_nibble = act_data_q[{idx_q, 2'b00} +: 4];

    seg7_hex_lut u_hex_lut (
        .nibble (cur_nibble),
        .seg    (lut_seg)
    );

    // Pin drive for the current slot; dark during dead-time and for blanked digits.
    always_comb begin
        slot_lit = (cnt_q >= CNT_W'(DEAD_CYCLES)) && !act_blank_q[idx_q];
        an_d     = {NUM_DIGITS{1'b1}};
        seg_d    = SEG_OFF;
        dp_n_d   = 1'b1;
        if (slot_lit) begin
            an_d   = ~(NUM_DIGITS'(1'b1) << idx_q);
            seg_d  = lut_seg;
            dp_n_d = ~act_dp_q[idx_q];
        end else begin
            an_d   = {NUM_DIGITS{1'b1}};
        end
    end

    // State and output registers; reset leaves the display dark until a commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= {CNT_W{1'b0}};
            idx_q        <= {IDX_W{1'b0}};
            pending_q    <= 1'b0;
            frame_tick_q <= 1'b0;
            sh_data_q    <= {DAT_W{1'b0}};
            sh_blank_q   <= {NUM_DIGITS{1'b1}};
            sh_dp_q      <= {NUM_DIGITS{1'b0}};
            sh_lz_q      <= 1'b0;
            act_data_q   <= {DAT_W{1'b0}};
            act_blank_q  <= {NUM_DIGITS{1'b1}};
            act_dp_q     <= {NUM_DIGITS{1'b0}};
            an_q         <= {NUM_DIGITS{1'b1}};
            seg_q        <= SEG_OFF;
            dp_n_q       <= 1'b1;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            frame_tick_q <= frame_tick_d;
            sh_data_q    <= sh_data_d;
            sh_blank_q   <= sh_blank_d;
            sh_dp_q      <= sh_dp_d;
            sh_lz_q      <= sh_lz_d;
            act_data_q   <= act_data_d;
            act_blank_q  <= act_blank_d;
            act_dp_q     <= act_dp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_n_q       <= dp_n_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp_n       = dp_n_q;
    assign pending    = pending_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed plus randomized bench for seg7_scan_driver
// (4 digits, dwell 8, dead 2). A time-based reference model derives the expected
// pins from the global cycle count since reset and the committed display content.
module tb_seg7_scan_driver;

    localparam int N     = 4;
    localparam int DWELL = 8;
    localparam int DEAD  = 2;
    localparam int FRAME = N * DWELL;

    localparam logic [6:0] HEX [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   data = 16'h0000;
    logic [3:0]    blank = 4'h0;
    logic [3:0]    dp = 4'h0;
    logic          lz_en = 1'b0;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          dp_n;
    logic          pending;
    logic          frame_tick;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int          t;
    bit          m_pend;
    logic [15:0] m_sh_data;
    logic [3:0]  m_sh_blank;
    logic [3:0]  m_sh_dp;
    bit          m_sh_lz;
    bit          m_lit [N];
    logic [6:0]  m_seg [N];
    bit          m_dp  [N];

    // Observation window statistics
    int          lit_cnt  [N];
    logic [6:0]  last_seg [N];
    logic        last_dpn [N];
    int          seen_1111;

    seg7_scan_driver #(
        .NUM_DIGITS   (N),
        .DWELL_CYCLES (DWELL),
        .DEAD_CYCLES  (DEAD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .data       (data),
        .blank      (blank),
        .dp         (dp),
        .lz_en      (lz_en),
        .an         (an),
        .seg        (seg),
        .dp_n       (dp_n),
        .pending    (pending),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Copy the shadow into the displayed content, applying leading-zero suppression:
    // every digit above the highest non-zero one is dark (digit 0 always kept).
    task automatic model_commit();
        int top;
        top = 0;
        for (int i = 0; i < N; i++) if (m_sh_data[4*i +: 4] != 4'h0) top = i;
        for (int i = 0; i < N; i++) begin
            m_seg[i] = HEX[m_sh_data[4*i +: 4]];
            m_dp[i]  = m_sh_dp[i];
            m_lit[i] = !(m_sh_blank[i] || (m_sh_lz && i > top));
        end
    endtask

    task automatic clear_window();
        for (int i = 0; i < N; i++) begin
            lit_cnt[i]  = 0;
            last_seg[i] = 7'h7F;
            last_dpn[i] = 1'b1;
        end
    endtask

    // One clock: predict pins from the scan position before the edge, advance the
    // model, then compare every output shortly after the edge.
    task automatic tick();
        int pos, slot, c;
        bit wrap, lit, ld;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dpn;
        pos  = t % FRAME;
        wrap = (pos == FRAME - 1);
        slot = pos / DWELL;
        c    = pos % DWELL;
        ld   = load;
        lit  = (c >= DEAD) && m_lit[slot];
        e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1;
        if (lit) begin
            e_an[slot] = 1'b0;
            e_seg      = m_seg[slot];
            e_dpn      = !m_dp[slot];
        end
        if (wrap && m_pend) model_commit();
        if (ld) begin
            m_sh_data = data; m_sh_blank = blank; m_sh_dp = dp; m_sh_lz = lz_en;
            m_pend = 1'b1;
        end else if (wrap) begin
            m_pend = 1'b0;
        end
        t++;
        @(posedge clk);
        #1;
        chk("an",         32'(an),         32'(e_an));
        chk("seg",        32'(seg),        32'(e_seg));
        chk("dp_n",       32'(dp_n),       32'(e_dpn));
        chk("pending",    32'(pending),    32'(m_pend));
        chk("frame_tick", 32'(frame_tick), 32'(wrap));
        for (int s = 0; s < N; s++) begin
            if (an[s] == 1'b0) begin
                lit_cnt[s]++;
                last_seg[s] = seg;
                last_dpn[s] = dp_n;
            end
        end
        if (an != 4'hF && seg == 7'b1001111) seen_1111++;
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        load  = 1'b0;
        #1;
        chk("rst_an",      32'(an),         32'(4'hF));
        chk("rst_seg",     32'(seg),        32'(7'h7F));
        chk("rst_dp_n",    32'(dp_n),       32'(1'b1));
        chk("rst_pending", 32'(pending),    32'(1'b0));
        chk("rst_tick",    32'(frame_tick), 32'(1'b0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        t = 0;
        m_pend = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_lit[i] = 1'b0; m_seg[i] = 7'h7F; m_dp[i] = 1'b0;
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] b,
                           input logic [3:0] p, input logic lz);
        data = d; blank = b; dp = p; lz_en = lz;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic align_frame();
        while (t % FRAME != 0) tick();
    endtask

    task automatic run_window();
        clear_window();
        repeat (FRAME) tick();
    endtask

    initial begin
        // 1. reset state, display dark with no load
        do_reset();
        repeat (FRAME + 8) tick();

        // 2. plain hex content with a decimal point on digit 1
        do_reset();
        do_load(16'h12AF, 4'b0000, 4'b0010, 1'b0);
        chk("pending_after_load", 32'(pending), 32'(1'b1));
        align_frame();
        run_window();
        chk("d0_lit_cycles", 32'(lit_cnt[0]), 32'(DWELL - DEAD));
        chk("d0_seg_F",      32'(last_seg[0]), 32'(7'b0111000));
        chk("d0_dp_off",     32'(last_dpn[0]), 32'(1'b1));
        chk("d1_seg_A",      32'(last_seg[1]), 32'(7'b0001000));
        chk("d1_dp_on",      32'(last_dpn[1]), 32'(1'b0));
        chk("d3_seg_1",      32'(last_seg[3]), 32'(7'b1001111));

        // 3. leading zeros suppressed above a single digit
        do_load(16'h0005, 4'b0000, 4'b1110, 1'b1);
        align_frame();
        run_window();
        chk("lz5_d3_dark", 32'(lit_cnt[3]), 32'(0));
        chk("lz5_d2_dark", 32'(lit_cnt[2]), 32'(0));
        chk("lz5_d1_dark", 32'(lit_cnt[1]), 32'(0));
        chk("lz5_d0_seg",  32'(last_seg[0]), 32'(7'b0100100));

        // 4. all-zero value keeps only digit 0
        do_load(16'h0000, 4'b0000, 4'b0000, 1'b1);
        align_frame();
        run_window();
        chk("lz0_d0_cycles", 32'(lit_cnt[0]), 32'(DWELL - DEAD));
        chk("lz0_d0_seg",    32'(last_seg[0]), 32'(7'b0000001));
        chk("lz0_d3_dark",   32'(lit_cnt[3]), 32'(0));

        // 5a. two loads in one frame: the last one wins
        seen_1111 = 0;
        do_load(16'h1111, 4'b0000, 4'b0000, 1'b0);
        repeat (3) tick();
        do_load(16'h2222, 4'b0000, 4'b0000, 1'b0);
        align_frame();
        run_window();
        chk("no_1111_shown", 32'(seen_1111), 32'(0));
        chk("d3_seg_2",      32'(last_seg[3]), 32'(7'b0010010));

        // 5b. load on the wrap cycle: old shadow commits, new one waits a frame
        do_load(16'h4444, 4'b0000, 4'b0000, 1'b0);
        while (t % FRAME != FRAME - 1) tick();
        do_load(16'h3333, 4'b0000, 4'b0000, 1'b0);
        chk("wrap_load_pending", 32'(pending), 32'(1'b1));
        run_window();
        chk("wrap_d3_seg_4", 32'(last_seg[3]), 32'(7'b1001100));
        run_window();
        chk("wrap_d3_seg_3", 32'(last_seg[3]), 32'(7'b0000110));

        // Randomized loads at arbitrary scan positions
        for (int k = 0; k < 30; k++) begin
            logic [15:0] mask;
            case ($urandom_range(0, 4))
                0:       mask = 16'hFFFF;
                1:       mask = 16'h0FFF;
                2:       mask = 16'h00FF;
                3:       mask = 16'h000F;
                default: mask = 16'h0000;
            endcase
            repeat ($urandom_range(0, 45)) tick();
            do_load(16'($urandom) & mask,
                    4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)));
        end
        repeat (2 * FRAME) tick();

        // 6. asynchronous reset mid-slot discards everything
        repeat (11) tick();
        do_load(16'h9876, 4'b0000, 4'b0000, 1'b0);
        do_reset();
        repeat (2 * FRAME) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
